// File: rtl/alu_issue_scheduler.sv
// Purpose: ALU reservation station; wakes sources from the result bus and issues up to NUM_ALU oldest-ready ops per cycle.
// Latency: dispatch to earliest issue is 2 edges (write, then registered issue); a wakeup makes the entry eligible one cycle later.
// Backpressure: disp_ready is a registered "not full"; issue lanes never stall because the ALUs are single-cycle.
module alu_issue_scheduler #(
    parameter int RS_DEPTH = 8,
    parameter int NUM_ALU  = 2,
    parameter int TAG_W    = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [3:0]                   disp_optype,
    input  logic [TAG_W-1:0]             disp_src1_tag,
    input  logic                         disp_src1_rdy,
    input  logic [31:0]                  disp_src1_data,
    input  logic [TAG_W-1:0]             disp_src2_tag,
    input  logic                         disp_src2_rdy,
    input  logic [31:0]                  disp_src2_data,
    input  logic [31:0]                  disp_imm,
    input  logic [TAG_W-1:0]             disp_dst_tag,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [31:0]                  cdb_data,
    output logic [NUM_ALU-1:0]           alu_number,
    output logic [4*NUM_ALU-1:0]         iss_optype,
    output logic [32*NUM_ALU-1:0]        iss_sr1,
    output logic [32*NUM_ALU-1:0]        iss_sr2,
    output logic [32*NUM_ALU-1:0]        iss_imm,
    output logic [TAG_W*NUM_ALU-1:0]     iss_dst_tag,
    output logic [$clog2(RS_DEPTH):0]    rs_count
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [3:0]       optype;
        logic [TAG_W-1:0] s1_tag;
        logic             s1_rdy;
        logic [31:0]      s1_dat;
        logic [TAG_W-1:0] s2_tag;
        logic             s2_rdy;
        logic [31:0]      s2_dat;
        logic [31:0]      imm;
        logic [TAG_W-1:0] dst_tag;
    } ent_t;

    ent_t                ent_q     [RS_DEPTH];
    ent_t                ent_nxt   [RS_DEPTH];
    logic [RS_DEPTH-1:0] vld_q;
    logic [RS_DEPTH-1:0] vld_nxt;
    // older_q[i][j] set means entry i was dispatched before entry j
    logic [RS_DEPTH-1:0] older_q   [RS_DEPTH];
    logic [RS_DEPTH-1:0] older_nxt [RS_DEPTH];

    logic [RS_DEPTH-1:0] elig;
    logic [CNT_W-1:0]    rank      [RS_DEPTH];
    logic [RS_DEPTH-1:0] issue_mask;
    logic [NUM_ALU-1:0]  lane_vld;
    ent_t                lane_ent  [NUM_ALU];
    logic [CNT_W-1:0]    n_issue;
    logic [CNT_W-1:0]    count_nxt;
    logic [IDX_W-1:0]    free_idx;
    logic                disp_fire;
    ent_t                disp_ent;

    assign disp_fire = disp_valid & disp_ready;

    // Rank = number of eligible entries older than this one; rank k goes to lane k.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            elig[i] = vld_q[i] & ent_q[i].s1_rdy & ent_q[i].s2_rdy;
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            rank[i] = '0;
            for (int j = 0; j < RS_DEPTH; j++) begin
                rank[i] = rank[i] + CNT_W'(elig[j] & older_q[j][i]);
            end
        end
        issue_mask = '0;
        n_issue    = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            lane_vld[k] = 1'b0;
            lane_ent[k] = '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (elig[i] && rank[i] == CNT_W'(k)) begin
                    lane_vld[k]   = 1'b1;
                    lane_ent[k]   = ent_q[i];
                    issue_mask[i] = 1'b1;
                end
            end
            n_issue = n_issue + CNT_W'(lane_vld[k]);
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!vld_q[i]) free_idx = IDX_W'(i);
        end
    end

    // Tag 0 is the hardwired zero register; otherwise take dispatch data, else bypass from the bus.
    always_comb begin
        disp_ent         = '0;
        disp_ent.optype  = disp_optype;
        disp_ent.s1_tag  = disp_src1_tag;
        disp_ent.s2_tag  = disp_src2_tag;
        disp_ent.imm     = disp_imm;
        disp_ent.dst_tag = disp_dst_tag;
        if (disp_src1_tag == '0) begin
            disp_ent.s1_rdy = 1'b1;
        end else if (disp_src1_rdy) begin
            disp_ent.s1_rdy = 1'b1;
            disp_ent.s1_dat = disp_src1_data;
        end else if (cdb_valid && cdb_tag == disp_src1_tag) begin
            disp_ent.s1_rdy = 1'b1;
            disp_ent.s1_dat = cdb_data;
        end
        if (disp_src2_tag == '0) begin
            disp_ent.s2_rdy = 1'b1;
        end else if (disp_src2_rdy) begin
            disp_ent.s2_rdy = 1'b1;
            disp_ent.s2_dat = disp_src2_data;
        end else if (cdb_valid && cdb_tag == disp_src2_tag) begin
            disp_ent.s2_rdy = 1'b1;
            disp_ent.s2_dat = cdb_data;
        end
    end

    always_comb begin
        vld_nxt = vld_q & ~issue_mask;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_nxt[i]   = ent_q[i];
            older_nxt[i] = older_q[i];
            if (cdb_valid && vld_q[i]) begin
                if (!ent_q[i].s1_rdy && ent_q[i].s1_tag == cdb_tag) begin
                    ent_nxt[i].s1_rdy = 1'b1;
                    ent_nxt[i].s1_dat = cdb_data;
                end
                if (!ent_q[i].s2_rdy && ent_q[i].s2_tag == cdb_tag) begin
                    ent_nxt[i].s2_rdy = 1'b1;
                    ent_nxt[i].s2_dat = cdb_data;
                end
            end
        end
        if (disp_fire) begin
            vld_nxt[free_idx]   = 1'b1;
            ent_nxt[free_idx]   = disp_ent;
            older_nxt[free_idx] = '0;
            for (int j = 0; j < RS_DEPTH; j++) begin
                older_nxt[j][free_idx] = (IDX_W'(j) != free_idx);
            end
        end
        count_nxt = rs_count + CNT_W'(disp_fire) - n_issue;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            rs_count    <= '0;
            disp_ready  <= 1'b0;
            alu_number  <= '0;
            iss_optype  <= '0;
            iss_sr1     <= '0;
            iss_sr2     <= '0;
            iss_imm     <= '0;
            iss_dst_tag <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q      <= '0;
            rs_count   <= '0;
            disp_ready <= 1'b1;
            alu_number <= '0;
        end else begin
            vld_q      <= vld_nxt;
            rs_count   <= count_nxt;
            disp_ready <= (count_nxt < CNT_W'(RS_DEPTH));
            alu_number <= lane_vld;
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i]   <= ent_nxt[i];
                older_q[i] <= older_nxt[i];
            end
            for (int k = 0; k < NUM_ALU; k++) begin
                if (lane_vld[k]) begin
                    iss_optype[4*k +: 4]           <= lane_ent[k].optype;
                    iss_sr1[32*k +: 32]            <= lane_ent[k].s1_dat;
                    iss_sr2[32*k +: 32]            <= lane_ent[k].s2_dat;
                    iss_imm[32*k +: 32]            <= lane_ent[k].imm;
                    iss_dst_tag[TAG_W*k +: TAG_W]  <= lane_ent[k].dst_tag;
                end
            end
        end
    end

endmodule
